// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_stage
//  Purpose  : RISC-V fetch stage. Owns the PC, issues one instruction-memory
//             request at a time, registers returned words into the IF/ID
//             register, absorbs decode back-pressure with a one-entry skid
//             buffer and handles branch/jump redirects (including squashing
//             a response that is already in flight).
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  // instruction memory request/response
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  // redirect from downstream
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  // IF/ID register
  input  logic                  id_stall,
  output logic                  if_valid,
  output logic [31:0]           if_instruction,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_pc_plus4
);

  localparam logic [31:0]           C_NOP        = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] C_ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] C_FOUR       = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_squash;
  logic                  r_if_valid;
  logic [31:0]           r_if_instruction;
  logic [DATA_WIDTH-1:0] r_if_pc;
  logic                  r_skid_valid;
  logic [31:0]           r_skid_instr;
  logic [DATA_WIDTH-1:0] r_skid_pc;

  logic [DATA_WIDTH-1:0] w_redirect_pc;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic                  w_out_free;

  // Redirect targets are always word aligned; the low bits are simply dropped.
  assign w_redirect_pc = redirect_pc & C_ALIGN_MASK;
  assign w_pc_plus4    = r_pc + C_FOUR;
  // IF/ID can accept a new word if it is empty or being consumed this cycle.
  assign w_out_free    = !r_if_valid || !id_stall;

  // Fetch FSM, PC, squash flag, skid buffer and IF/ID register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state          <= S_IDLE;
      r_pc             <= RESET_PC & C_ALIGN_MASK;
      r_squash         <= 1'b0;
      r_if_valid       <= 1'b0;
      r_if_instruction <= C_NOP;
      r_if_pc          <= '0;
      r_skid_valid     <= 1'b0;
      r_skid_instr     <= C_NOP;
      r_skid_pc        <= '0;
    end else begin
      // Decode takes the current instruction; a load below overrides this.
      if (r_if_valid && !id_stall) begin
        r_if_valid <= 1'b0;
      end

      if (redirect_valid) begin
        // Redirect wins over everything: new PC, IF/ID and skid flushed.
        r_pc         <= w_redirect_pc;
        r_if_valid   <= 1'b0;
        r_skid_valid <= 1'b0;
        case (r_state)
          S_REQ: begin
            if (imem_ready) begin
              // The request accepted this cycle fetches the old path.
              r_state  <= S_WAIT;
              r_squash <= 1'b1;
            end else begin
              r_state  <= S_REQ;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              // The in-flight word lands now and is simply dropped.
              r_state  <= S_REQ;
              r_squash <= 1'b0;
            end else begin
              // Keep waiting so only one request is ever outstanding.
              r_squash <= 1'b1;
            end
          end
          default: begin
            r_state <= S_REQ;
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_REQ;
          end
          S_REQ: begin
            if (imem_ready) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (r_squash) begin
                // Stale word from before a redirect; PC already holds target.
                r_squash <= 1'b0;
                r_state  <= S_REQ;
              end else if (w_out_free) begin
                r_if_instruction <= imem_rdata[31:0];
                r_if_pc          <= r_pc;
                r_if_valid       <= 1'b1;
                r_pc             <= w_pc_plus4;
                r_state          <= S_REQ;
              end else begin
                r_skid_instr <= imem_rdata[31:0];
                r_skid_pc    <= r_pc;
                r_skid_valid <= 1'b1;
                r_pc         <= w_pc_plus4;
                r_state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!id_stall) begin
              // Decode consumes IF/ID this cycle and the skid word replaces it.
              if (r_skid_valid) begin
                r_if_instruction <= r_skid_instr;
                r_if_pc          <= r_skid_pc;
                r_if_valid       <= 1'b1;
              end
              r_skid_valid <= 1'b0;
              r_state      <= S_REQ;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign imem_req       = (r_state == S_REQ);
  assign imem_addr      = r_pc & C_ALIGN_MASK;
  assign if_valid       = r_if_valid;
  assign if_instruction = r_if_instruction;
  assign if_pc          = r_if_pc;
  assign if_pc_plus4    = r_if_pc + C_FOUR;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_stage
//  Purpose  : Self-checking bench for instruction_fetch_stage. A transaction
//             level model (outstanding-request flag, skid queue, IF/ID slot)
//             is compared against the DUT every cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  instruction_fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout actual=no-event required=event", nm);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h0)      return 32'h00500093;
    else if (a == 32'h4) return 32'h00A00113;
    else                 return a ^ 32'h5A5A_0013;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} slot_t;
  slot_t       m_held[$];
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h13;
  logic [31:0] m_opc   = 32'h0;
  bit          m_valid = 0;
  bit          m_start = 1;
  bit          m_out   = 0;
  bit          m_stale = 0;
  bit          mr_req, mr_cons, mr_loaded;
  slot_t       mr_s;

  // A request is on the bus whenever nothing is outstanding or parked.
  function automatic bit m_req();
    return !m_start && !m_out && (m_held.size() == 0);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pc = 32'h0; m_instr = 32'h13; m_opc = 32'h0;
      m_valid = 0; m_start = 1; m_out = 0; m_stale = 0;
      m_held.delete();
    end else begin
      mr_req    = m_req();
      mr_cons   = m_valid && !id_stall;
      mr_loaded = 0;
      if (redirect_valid) begin
        if (mr_req && imem_ready)       begin m_out = 1; m_stale = 1; end
        else if (m_out && imem_rvalid)  begin m_out = 0; m_stale = 0; end
        else if (m_out)                 m_stale = 1;
        m_pc    = redirect_pc & 32'hFFFF_FFFC;
        m_valid = 0;
        m_start = 0;
        m_held.delete();
      end else begin
        if (m_start) begin
          m_start = 0;
        end else if (m_held.size() != 0) begin
          if (!id_stall) begin
            mr_s = m_held.pop_front();
            m_instr = mr_s.instr; m_opc = mr_s.pc; mr_loaded = 1;
          end
        end else if (mr_req) begin
          if (imem_ready) m_out = 1;
        end else if (m_out && imem_rvalid) begin
          m_out = 0;
          if (m_stale) begin
            m_stale = 0;
          end else begin
            if (!m_valid || !id_stall) begin
              m_instr = imem_rdata; m_opc = m_pc; mr_loaded = 1;
            end else begin
              m_held.push_back('{imem_rdata, m_pc});
            end
            m_pc = m_pc + 32'd4;
          end
        end
        if (mr_loaded)    m_valid = 1;
        else if (mr_cons) m_valid = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("req", 32'(imem_req), 32'(m_req()));
      if (m_req()) chk("addr", imem_addr, m_pc);
      chk("valid", 32'(if_valid), 32'(m_valid));
      if (m_valid) begin
        chk("instr", if_instruction, m_instr);
        chk("ifpc", if_pc, m_opc);
        chk("pc4", if_pc_plus4, m_opc + 32'd4);
      end
    end
  end

  // ---------------- memory responder and logs ----------------
  typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic [31:0] p4;} cons_t;
  cons_t       consq[$];
  logic [31:0] acc_addrs[$];
  int          req_len[$];
  int          ready_stall = 0;
  int          resp_lat    = 0;
  int          mlat        = 0;
  int          req_cycles  = 0;
  int          acc_cnt     = 0;
  bit          mpend       = 0;
  logic [31:0] maddr       = 32'h0;

  initial begin
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk); #1;
      imem_ready  = rstn && imem_req && (ready_stall == 0);
      imem_rvalid = mpend && (mlat == 0);
      imem_rdata  = imem_rvalid ? instr_of(maddr) : 32'hDEAD_BEEF;
      #1;
      if (imem_rvalid)            mpend = 0;
      else if (mpend && mlat > 0) mlat--;
      if (imem_req && imem_ready) begin
        mpend = 1; maddr = imem_addr; mlat = resp_lat;
        acc_addrs.push_back(imem_addr);
        req_len.push_back(req_cycles + 1);
        req_cycles = 0;
        acc_cnt++;
      end else if (imem_req) begin
        req_cycles++;
        if (ready_stall > 0) ready_stall--;
      end
      if (rstn && if_valid && !id_stall) consq.push_back('{if_pc, if_instruction, if_pc_plus4});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_acc(input string nm);
    int c;
    int n;
    c = acc_cnt;
    n = 0;
    while (acc_cnt == c && n < 60) begin step(); n++; end
    if (acc_cnt == c) fail_timeout(nm);
  endtask

  task automatic wait_req(input bit want, input string nm);
    int n;
    n = 0;
    while (imem_req !== want && n < 60) begin step(); n++; end
    if (imem_req !== want) fail_timeout(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int          a, k, c, n;
  logic [31:0] p;

  initial begin
    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    @(posedge clk); chk_on = 1;
    repeat (3) step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_instr", if_instruction, 32'h13);
    chk("rst_ifpc",  if_pc, 32'h0);
    chk("rst_pc4",   if_pc_plus4, 32'h4);

    // sequential fetch, 1-cycle memory
    rstn = 1'b1;
    #1 chk("idle_req", 32'(imem_req), 32'd0);
    step();
    chk("first_req",  32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    repeat (8) step();
    chk("seq_acc0", acc_addrs[0], 32'h0);
    chk("seq_acc1", acc_addrs[1], 32'h4);
    chk("seq_pc0",  consq[0].pc, 32'h0);
    chk("seq_in0",  consq[0].instr, 32'h00500093);
    chk("seq_p40",  consq[0].p4, 32'h4);
    chk("seq_pc1",  consq[1].pc, 32'h4);
    chk("seq_in1",  consq[1].instr, 32'h00A00113);
    chk("seq_p41",  consq[1].p4, 32'h8);

    // memory back-pressure: ready low for 3 cycles
    wait_req(1'b0, "bp_idle");
    ready_stall = 3;
    wait_acc("bp_acc");
    chk("bp_len", 32'(req_len[req_len.size()-1]), 32'd4);

    // decode stall while a response arrives
    step();
    n = 0;
    while (!(if_valid && imem_req) && n < 60) begin step(); n++; end
    if (!(if_valid && imem_req)) fail_timeout("stall_start");
    k = consq.size(); c = acc_cnt; p = m_opc;
    id_stall = 1'b1;
    repeat (4) step();
    chk("stall_noreq", 32'(acc_cnt), 32'(c + 1));
    chk("stall_held",  32'(if_valid), 32'd1);
    id_stall = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      chk("stall_order_pc", consq[k+i].pc, p + 32'(4*i));
      chk("stall_order_in", consq[k+i].instr, instr_of(p + 32'(4*i)));
    end

    // redirect in WAIT one cycle before the response
    resp_lat = 1;
    wait_acc("rw_acc");
    a = acc_addrs.size();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    k = consq.size();
    repeat (8) step();
    chk("rw_addr", acc_addrs[a], 32'h100);
    chk("rw_pc",   consq[k].pc, 32'h100);
    chk("rw_in",   consq[k].instr, instr_of(32'h100));

    // redirect together with the response
    wait_acc("rr_acc");
    step();
    a = acc_addrs.size();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    k = consq.size();
    repeat (8) step();
    chk("rr_addr", acc_addrs[a], 32'h200);
    chk("rr_pc",   consq[k].pc, 32'h200);

    // redirect together with request acceptance (misaligned target)
    resp_lat = 2;
    wait_req(1'b1, "rq_req");
    a = acc_addrs.size();
    redirect_valid = 1'b1; redirect_pc = 32'h302;
    step();
    redirect_valid = 1'b0;
    k = consq.size();
    repeat (12) step();
    chk("rq_addr", acc_addrs[a+1], 32'h300);
    chk("rq_pc",   consq[k].pc, 32'h300);

    // wrap-around
    resp_lat = 0;
    wait_req(1'b0, "wr_idle");
    a = acc_addrs.size();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    k = consq.size();
    repeat (8) step();
    chk("wr_addr0", acc_addrs[a], 32'hFFFF_FFFC);
    chk("wr_addr1", acc_addrs[a+1], 32'h0);
    chk("wr_pc",    consq[k].pc, 32'hFFFF_FFFC);
    chk("wr_pc4",   consq[k].p4, 32'h0);
    chk("wr_next",  consq[k+1].pc, 32'h0);

    // reset pulsed during WAIT, late response afterwards
    resp_lat = 3;
    wait_acc("mr_acc");
    step();
    rstn = 1'b0;
    resp_lat = 0;
    step();
    chk("mr_valid", 32'(if_valid), 32'd0);
    chk("mr_req",   32'(imem_req), 32'd0);
    chk("mr_instr", if_instruction, 32'h13);
    chk("mr_ifpc",  if_pc, 32'h0);
    a = acc_addrs.size(); k = consq.size();
    rstn = 1'b1;
    repeat (10) step();
    chk("mr_addr", acc_addrs[a], 32'h0);
    chk("mr_pc",   consq[k].pc, 32'h0);
    chk("mr_in",   consq[k].instr, 32'h00500093);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the RISC-V core. It owns the program counter and issues one instruction-memory request at a time through a ready/valid handshake. Each returned word is registered into the IF/ID output register, which the decode stage, the immediate generator and the control unit consume. The block handles decode back-pressure with a one-entry skid buffer and handles branch/jump redirects, including squashing a response that is already in flight.

## Interface
- DATA_WIDTH, 32: width of PC, address and instruction paths.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- imem_req  out  1  request valid; asserted only in state REQ.
- imem_addr  out  DATA_WIDTH  request address = pc, bits [1:0] always 0.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; meaningful only in state WAIT.
- imem_rdata  in  DATA_WIDTH  instruction word.
- redirect_valid  in  1  taken branch, JAL or JALR from downstream.
- redirect_pc  in  DATA_WIDTH  redirect target; bits [1:0] forced to 0 internally.
- id_stall  in  1  decode cannot take a new instruction this cycle.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_instruction  out  32  IF/ID instruction.
- if_pc  out  DATA_WIDTH  address of if_instruction.
- if_pc_plus4  out  DATA_WIDTH  if_pc + 4, modulo 2^DATA_WIDTH (combinational from if_pc).

## Operation
- State: pc register, FSM {IDLE, REQ, WAIT, HOLD}, squash flag, skid buffer (instr + pc).
- IDLE: imem_req = 0. Goes to REQ on the next cycle, unconditionally.
- REQ: imem_req = 1, imem_addr = pc.
  - imem_ready = 1: go to WAIT.
  - Otherwise stay in REQ, holding the address stable.
- WAIT: no request is issued.
  - imem_rvalid with squash = 1: discard the data, clear squash, go to REQ. pc is unchanged because it already holds the redirect target.
  - imem_rvalid with the output free (if_valid = 0 or id_stall = 0): load the IF/ID register, set if_valid = 1, pc <= pc + 4, go to REQ.
  - imem_rvalid with the output blocked (if_valid = 1 and id_stall = 1): write the word and pc into the skid buffer, pc <= pc + 4, go to HOLD.
- HOLD: stay while id_stall = 1. When id_stall = 0, move the skid buffer into IF/ID (if_valid stays 1) and go to REQ.
- Consumption: if_valid = 1 and id_stall = 0 with no new load in that cycle clears if_valid.
- Redirect has highest priority and overrides every rule above in the same cycle:
  - pc <= redirect_pc.
  - if_valid <= 0 and the skid buffer is invalidated.
  - From REQ, IDLE or HOLD: go to REQ.
  - From WAIT without imem_rvalid: stay in WAIT and set squash = 1.
  - From WAIT with imem_rvalid in the same cycle: discard the data, go to REQ, squash stays 0.
  - From REQ with imem_ready in the same cycle: the accepted request is stale, so go to WAIT with squash = 1.
- Outstanding requests never exceed one.

## Timing
- Reset values: pc = RESET_PC, state = IDLE, squash = 0, if_valid = 0, if_instruction = 32'h0000_0013 (NOP), if_pc = 0, skid buffer invalid, imem_req = 0.
- First imem_req appears 2 cycles after rstn deasserts (IDLE, then REQ).
- Reset asserted mid-transaction returns immediately to reset values. A late imem_rvalid after reset is ignored because the FSM is not in WAIT.
- Latency: if_valid rises on the edge that samples imem_rvalid.
- Best-case throughput is one instruction per 2 cycles (REQ, then WAIT with 1-cycle memory).
- pc, if_pc and if_pc_plus4 wrap modulo 2^DATA_WIDTH (0xFFFF_FFFC + 4 = 0).

## Test plan
- Reset and sequential fetch with 1-cycle memory returning 0x00500093, 0x00A00113:
  - imem_addr sequence 0x0, 0x4.
  - if_pc 0x0 then 0x4; if_pc_plus4 0x4 then 0x8; if_valid never set during reset.
- Memory back-pressure: imem_ready low for 3 cycles in REQ -> imem_req and imem_addr held stable for 3 cycles; no duplicate request.
- Decode stall: id_stall high for 4 cycles while if_valid = 1 and a response arrives.
  - That word enters HOLD and no new request is issued.
  - After the stall releases, if_instruction updates in order with no loss or duplication.
- Redirect in WAIT: redirect to 0x100 one cycle before imem_rvalid.
  - The stale word is dropped and the next imem_addr is 0x100.
  - if_valid = 0 until the 0x100 word arrives.
- Simultaneous redirect + imem_rvalid, and redirect + imem_ready in REQ -> no stale instruction ever reaches if_valid = 1; the next delivered if_pc equals the redirect target.
- Wrap-around and mid-fetch reset:
  - Fetch at 0xFFFF_FFFC -> next imem_addr is 0x0.
  - rstn pulsed low during WAIT -> all outputs return to reset values and fetch restarts at RESET_PC.
